fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a single IF/ID register and a
// one-entry skid buffer that parks a return arriving while decode is stalled.
module fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [31:0]     id_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     skid_q, skid_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic [31:0]     id_instr_q, id_instr_d;

  logic            slot_free;
  logic [XLEN-1:0] pc_plus4;

  assign slot_free = ~id_valid_q | ~stall;
  assign pc_plus4  = pc_q + XLEN'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    skid_d     = skid_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_instr_d = id_instr_q;

    if (redirect) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      id_valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      // Decode consumes the entry whenever it is not stalled.
      if (slot_free) id_valid_d = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (slot_free) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc_d    = pc_q;
              id_pc4_d   = pc_plus4;
              pc_d       = pc_plus4;
              state_d    = S_REQ;
            end else begin
              skid_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end
        default: begin
          // pc still points at the parked instruction until it moves into IF/ID.
          if (!stall) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_q;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            pc_d       = pc_plus4;
            state_d    = S_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      skid_q     <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      skid_q     <= skid_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign imem_req  = reset & (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc4_q;
  assign id_instr  = id_instr_q;

endmodule
